// File: rtl/alu_cmd_issuer.sv
// Command front end for the 64-bit combinational ALU: queues commands, holds the
// ALU inputs for SETTLE cycles, captures result/carry and returns them with the tag.
module alu_cmd_issuer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2,
  parameter int TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [63:0]                  cmd_a,
  input  logic [63:0]                  cmd_b,
  input  logic [3:0]                   cmd_op,
  input  logic [TAG_W-1:0]             cmd_tag,
  output logic [63:0]                  alu_a,
  output logic [63:0]                  alu_b,
  output logic [3:0]                   alu_op,
  input  logic [63:0]                  alu_result,
  input  logic                         alu_carry,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [63:0]                  rsp_result,
  output logic                         rsp_carry,
  output logic                         rsp_err,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef struct packed {
    logic [63:0]      a;
    logic [63:0]      b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t              r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [SCNT_W-1:0] r_settle;
  state_t            r_state, w_next_state;

  logic              r_rsp_valid, r_rsp_carry, r_rsp_err;
  logic [63:0]       r_rsp_result, r_alu_a, r_alu_b;
  logic [3:0]        r_alu_op;
  logic [TAG_W-1:0]  r_rsp_tag;

  logic w_push, w_pop, w_load, w_rsp_done, w_not_empty, w_div0;
  cmd_t w_head;

  assign w_not_empty = (r_count != '0);
  assign cmd_ready   = (r_count != CNT_W'(DEPTH));
  assign w_push      = cmd_valid && cmd_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_div0      = (r_alu_op == OP_DIV) && (r_alu_b == '0);

  // NOTE: storage is left unreset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_not_empty) w_next_state = ISSUE;
      ISSUE:   if (r_settle == '0) w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = w_not_empty ? ISSUE : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    w_load     = 1'b0;
    w_pop      = 1'b0;
    w_rsp_done = 1'b0;
    unique case (r_state)
      IDLE:    w_load = w_not_empty;
      ISSUE:   w_pop  = (r_settle == '0);
      RESP: begin
        w_rsp_done = rsp_ready;
        w_load     = rsp_ready && w_not_empty;
      end
      default: ;
    endcase
  end

  // The head stays queued while in flight; it is popped only when its result is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_settle     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_tag    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      if (w_load) begin
        r_alu_a  <= w_head.a;
        r_alu_b  <= w_head.b;
        r_alu_op <= w_head.op;
        r_settle <= SCNT_W'(SETTLE - 1);
      end else if (r_state == ISSUE && r_settle != '0) begin
        r_settle <= r_settle - 1'b1;
      end

      if (w_pop) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= w_div0 ? '1 : alu_result;
        r_rsp_carry  <= w_div0 ? 1'b0 : alu_carry;
        r_rsp_err    <= w_div0;
        r_rsp_tag    <= w_head.tag;
      end else if (w_rsp_done) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_err    = r_rsp_err;
  assign rsp_tag    = r_rsp_tag;
  assign fifo_count = r_count;
  assign busy       = (r_state != IDLE) || w_not_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: an ALU stand-in that only yields a true result once its
// inputs have been stable SETTLE cycles, plus an in-order scoreboard of expected responses.
module tb_alu_cmd_issuer;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [63:0]       cmd_a, cmd_b;
  logic [3:0]        cmd_op;
  logic [TAG_W-1:0]  cmd_tag;
  logic [63:0]       alu_a, alu_b, alu_result;
  logic [3:0]        alu_op;
  logic              alu_carry;
  logic              rsp_valid, rsp_ready, rsp_carry, rsp_err, busy;
  logic [63:0]       rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic [CNT_W-1:0]  fifo_count;

  alu_cmd_issuer #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  typedef struct packed {
    logic [63:0]      res;
    logic             carry;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];

  // Reference ALU: {carry, result}. Unknown opcodes produce an arbitrary but fixed mix.
  function automatic logic [64:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0000: return {1'b0, a} + {1'b0, b};
      4'b0001: return {1'b0, a} - {1'b0, b};
      4'b0010: return {1'b0, a * b};
      4'b0011: return (b == '0) ? 65'd0 : {1'b0, a / b};
      4'b1000: return {1'b0, a & b};
      4'b1001: return {1'b0, a | b};
      4'b1010: return {1'b0, a ^ b};
      default: return {1'b1, a ^ {b[31:0], b[63:32]}};
    endcase
  endfunction

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] op, input logic [TAG_W-1:0] tag);
    logic [64:0] r;
    r = alu_ref(a, b, op);
    if (op == 4'b0011 && b == '0) return '{res: '1, carry: 1'b0, err: 1'b1, tag: tag};
    return '{res: r[63:0], carry: r[64], err: 1'b0, tag: tag};
  endfunction

  // ALU stand-in: garbage until its inputs have been stable for SETTLE cycles.
  logic [63:0] stab_a = '0, stab_b = '0;
  logic [3:0]  stab_op = '0;
  int          stab = 0;
  logic [64:0] ref_out;

  always @(negedge clk) begin
    if (alu_a == stab_a && alu_b == stab_b && alu_op == stab_op) begin
      if (stab < 1000) stab <= stab + 1;
    end else begin
      stab <= 1;
    end
    stab_a  <= alu_a;
    stab_b  <= alu_b;
    stab_op <= alu_op;
  end

  assign ref_out    = alu_ref(alu_a, alu_b, alu_op);
  assign alu_result = (stab >= SETTLE) ? ref_out[63:0] : 64'hBAD0_BAD0_BAD0_BAD0;
  assign alu_carry  = (stab >= SETTLE) ? ref_out[64] : 1'b1;

  // Compare process: runs on every falling edge out of reset.
  logic prev_hold = 1'b0;
  exp_t prev_rsp;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid",  rsp_valid,  1'b1);
        check("hold_result", rsp_result, prev_rsp.res);
        check("hold_tag",    rsp_tag,    prev_rsp.tag);
        check("hold_err",    rsp_err,    prev_rsp.err);
      end
      check("ready_vs_full", cmd_ready, fifo_count != CNT_W'(DEPTH));
      if (rsp_valid || fifo_count != '0) check("busy_active", busy, 1'b1);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          note_fail("spurious_rsp");
        end else begin
          check("rsp_result", rsp_result, sb[0].res);
          check("rsp_carry",  rsp_carry,  sb[0].carry);
          check("rsp_err",    rsp_err,    sb[0].err);
          check("rsp_tag",    rsp_tag,    sb[0].tag);
          sb.delete(0);
        end
      end
      prev_hold <= rsp_valid && !rsp_ready;
      prev_rsp  <= '{res: rsp_result, carry: rsp_carry, err: rsp_err, tag: rsp_tag};
    end
  end

  int t_acc = 0;

  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                      input logic [TAG_W-1:0] tag);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!cmd_ready) begin
      note_fail("push_timeout");
      cmd_valid = 1'b0;
      return;
    end
    sb.push_back(model(a, b, op, tag));
    @(posedge clk); #1;
    t_acc     = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin
        lat = cyc - t_acc;
        return;
      end
      @(posedge clk); #1;
    end
    note_fail("rsp_timeout");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy && !rsp_valid && fifo_count == '0) return;
    end
    note_fail("idle_timeout");
  endtask

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] lit;
  } vec_t;

  vec_t stream [8];
  int   lat;
  exp_t m;

  initial begin
    stream[0] = '{a: 64'd10,   b: 64'd3,    op: 4'b0001, lit: 64'd7};
    stream[1] = '{a: 64'd6,    b: 64'd7,    op: 4'b0010, lit: 64'd42};
    stream[2] = '{a: 64'hF0,   b: 64'h3C,   op: 4'b1000, lit: 64'h30};
    stream[3] = '{a: 64'hF0,   b: 64'h3C,   op: 4'b1001, lit: 64'hFC};
    stream[4] = '{a: 64'hF0,   b: 64'h3C,   op: 4'b1010, lit: 64'hCC};
    stream[5] = '{a: 64'd1,    b: 64'd2,    op: 4'b0000, lit: 64'd3};
    stream[6] = '{a: 64'h1234, b: 64'hFF,   op: 4'b0101, lit: 64'h0000_00FF_0000_1234};
    stream[7] = '{a: 64'd1000, b: 64'd10,   op: 4'b0011, lit: 64'd100};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_cmd_ready", cmd_ready,  1'b1);
    check("rst_rsp_valid", rsp_valid,  1'b0);
    check("rst_count",     fifo_count, 0);
    check("rst_busy",      busy,       1'b0);
    check("rst_alu_a",     alu_a,      0);
    check("rst_alu_op",    alu_op,     0);
    check("rst_result",    rsp_result, 0);

    // Single add and its latency.
    rsp_ready = 1'b1;
    push(64'd5, 64'd7, 4'b0000, 4'd3);
    wait_rsp(lat);
    check("add_latency", lat, 3);
    check("add_result",  rsp_result, 64'd12);
    check("add_carry",   rsp_carry,  1'b0);
    check("add_err",     rsp_err,    1'b0);
    check("add_tag",     rsp_tag,    4'd3);
    wait_idle();

    push(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 4'd5);
    wait_rsp(lat);
    check("carry_latency", lat, 3);
    check("carry_result",  rsp_result, 64'd0);
    check("carry_carry",   rsp_carry,  1'b1);
    wait_idle();

    push(64'd100, 64'd0, 4'b0011, 4'd9);
    wait_rsp(lat);
    check("div0_latency", lat, 3);
    check("div0_result",  rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("div0_carry",   rsp_carry,  1'b0);
    check("div0_err",     rsp_err,    1'b1);
    check("div0_tag",     rsp_tag,    4'd9);
    wait_idle();

    push(64'd100, 64'd7, 4'b0011, 4'd10);
    wait_rsp(lat);
    check("div_result", rsp_result, 64'd14);
    check("div_err",    rsp_err,    1'b0);
    wait_idle();

    // Fill under back-pressure: one in flight, four queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(64'(i * 3), 64'd100, 4'b0000, TAG_W'(i));
    check("fill_count",     fifo_count, 4);
    check("fill_cmd_ready", cmd_ready,  1'b0);
    check("fill_rsp_valid", rsp_valid,  1'b1);
    check("fill_rsp_tag",   rsp_tag,    4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("fill_count_held", fifo_count, 4);
    rsp_ready = 1'b1;
    wait_idle();
    check("fill_drained", sb.size(), 0);

    // Back-to-back stream of mixed ops; model pinned against hand-computed values.
    for (int i = 0; i < 8; i++) begin
      m = model(stream[i].a, stream[i].b, stream[i].op, TAG_W'(i));
      check("pin_model", m.res, stream[i].lit);
    end
    for (int i = 0; i < 8; i++) push(stream[i].a, stream[i].b, stream[i].op, TAG_W'(i));
    wait_idle();
    check("stream_drained", sb.size(), 0);

    // Reset while issuing with two commands queued behind the in-flight one.
    push(64'd1, 64'd1, 4'b0000, 4'd1);
    push(64'd2, 64'd2, 4'b0000, 4'd2);
    push(64'd3, 64'd3, 4'b0000, 4'd3);
    check("pre_rst_count", fifo_count, 3);
    check("pre_rst_valid", rsp_valid,  1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("mid_rst_valid", rsp_valid,  1'b0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy",  busy,       1'b0);
    check("mid_rst_alu_a", alu_a,      0);
    check("mid_rst_alu_b", alu_b,      0);
    check("mid_rst_alu_op", alu_op,    0);
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_valid", rsp_valid, 1'b0);
    check("post_rst_busy",  busy,      1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
